// File: rtl/r_channel_arbiter.sv
// r_channel_arbiter: burst-locked round-robin arbiter sharing one AXI R channel
// between NUM_SRC response sources. A winning source keeps the channel until
// its last beat completes, so bursts never interleave.
// Optional feature macro: R_ARB_BURST_CNT_EN adds a 16-bit completed-burst
// counter on output port burst_cnt.
module r_channel_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RESP_WIDTH = 2,
  localparam int unsigned PTR_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SRC-1:0]               src_valid,
  input  logic [NUM_SRC*ID_WIDTH-1:0]      src_id,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    src_data,
  input  logic [NUM_SRC*RESP_WIDTH-1:0]    src_resp,
  input  logic [NUM_SRC-1:0]               src_last,
  output logic [NUM_SRC-1:0]               src_ready,
  output logic                             out_valid,
  output logic [ID_WIDTH-1:0]              out_id,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [RESP_WIDTH-1:0]            out_resp,
  output logic                             out_last,
  input  logic                             out_ready,
`ifdef R_ARB_BURST_CNT_EN
  output logic [15:0]                      burst_cnt,
`endif
  output logic                             busy,
  output logic [PTR_W-1:0]                 grant_idx
);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] r_grant;
  logic [PTR_W-1:0] w_grant_nxt;
  logic [PTR_W-1:0] w_sel;
  logic [PTR_W-1:0] w_cand;
  logic             w_any;
  logic             w_done;

  // Round-robin search: first requesting source at or after r_ptr, with wrap.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_cand = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_cand = PTR_W'((32'(r_ptr) + k) % NUM_SRC);
      if (!w_any && src_valid[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  // Output mux from the locked source; everything quiet in IDLE or reset.
  always_comb begin
    out_valid = 1'b0;
    out_id    = '0;
    out_data  = '0;
    out_resp  = '0;
    out_last  = 1'b0;
    src_ready = '0;
    if (r_state == S_BURST && !rst) begin
      out_valid          = src_valid[r_grant];
      out_id             = src_id[32'(r_grant)*ID_WIDTH +: ID_WIDTH];
      out_data           = src_data[32'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
      out_resp           = src_resp[32'(r_grant)*RESP_WIDTH +: RESP_WIDTH];
      out_last           = src_last[r_grant];
      src_ready[r_grant] = out_ready;
    end
  end

  assign w_done    = out_valid & out_ready & out_last;
  assign busy      = (r_state == S_BURST);
  assign grant_idx = r_grant;

  // Next-state logic: lock on a winner in IDLE, release on the last handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_sel;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = (r_grant == PTR_W'(NUM_SRC - 1)) ? '0 : r_grant + PTR_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
    end
  end

`ifdef R_ARB_BURST_CNT_EN
  logic [15:0] r_burst_cnt;

  // Completed-burst counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst_cnt <= '0;
    end else if (w_done) begin
      r_burst_cnt <= r_burst_cnt + 16'd1;
    end
  end

  assign burst_cnt = r_burst_cnt;
`endif

endmodule

// File: tb/tb_r_channel_arbiter.sv
// Directed self-checking bench for r_channel_arbiter (NUM_SRC=4).
module tb_r_channel_arbiter;

  localparam int NS = 4;
  localparam int IW = 4;
  localparam int DW = 64;
  localparam int RW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src_valid;
  logic [NS*IW-1:0] src_id;
  logic [NS*DW-1:0] src_data;
  logic [NS*RW-1:0] src_resp;
  logic [NS-1:0]    src_last;
  logic [NS-1:0]    src_ready;
  logic             out_valid;
  logic [IW-1:0]    out_id;
  logic [DW-1:0]    out_data;
  logic [RW-1:0]    out_resp;
  logic             out_last;
  logic             out_ready;
  logic             busy;
  logic [1:0]       grant_idx;
`ifdef R_ARB_BURST_CNT_EN
  logic [15:0]      burst_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  r_channel_arbiter #(
    .NUM_SRC   (NS),
    .ID_WIDTH  (IW),
    .DATA_WIDTH(DW),
    .RESP_WIDTH(RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_id    (src_id),
    .src_data  (src_data),
    .src_resp  (src_resp),
    .src_last  (src_last),
    .src_ready (src_ready),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_data  (out_data),
    .out_resp  (out_resp),
    .out_last  (out_last),
    .out_ready (out_ready),
`ifdef R_ARB_BURST_CNT_EN
    .burst_cnt (burst_cnt),
`endif
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [IW-1:0] id,
                         input logic [DW-1:0] d, input logic l);
    src_valid[i]         = v;
    src_id[i*IW +: IW]   = id;
    src_data[i*DW +: DW] = d;
    src_resp[i*RW +: RW] = 2'b00;
    src_last[i]          = l;
  endtask

  int          beat [NS];
  logic [NS-1:0] hs;
  logic [7:0]  code;
  logic [7:0]  exp_code [10] = '{8'hFF, 8'h00, 8'h01, 8'hFF, 8'h10, 8'h11, 8'hFF, 8'h30, 8'h31, 8'hFF};
  logic        bp_rdy   [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [63:0] bp_data  [5]  = '{64'hA0, 64'hA1, 64'hA1, 64'hA1, 64'hA2};
  int          bp_beat;

  initial begin
    rst = 1'b1; src_valid = '0; src_id = '0; src_data = '0; src_resp = '0;
    src_last = '0; out_ready = 1'b1;

    // Reset state
    tick();
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(src_ready), 64'd0);
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    rst = 1'b0;

    // Single source: src 2, 4 beats, id 5
    set_src(2, 1'b1, 4'h5, 64'd0, 1'b0);
    #1;
    check("ss_lat0", 64'(out_valid), 64'd0);
    tick();
    check("ss_valid", 64'(out_valid), 64'd1);
    check("ss_grant", 64'(grant_idx), 64'd2);
    check("ss_busy", 64'(busy), 64'd1);
    check("ss_ready", 64'(src_ready), 64'b0100);
    for (int b = 0; b < 4; b++) begin
      set_src(2, 1'b1, 4'h5, 64'(b), (b == 3));
      #1;
      check("ss_data", out_data, 64'(b));
      check("ss_id", 64'(out_id), 64'h5);
      check("ss_last", 64'(out_last), (b == 3) ? 64'd1 : 64'd0);
      tick();
    end
    set_src(2, 1'b0, 4'h0, 64'd0, 1'b0);
    #1;
    check("ss_done_busy", 64'(busy), 64'd0);
    check("ss_done_valid", 64'(out_valid), 64'd0);

    // Wrap-around: ptr=3, sources 0 and 3 request
    set_src(0, 1'b1, 4'h0, 64'h10, 1'b1);
    set_src(3, 1'b1, 4'h3, 64'h30, 1'b1);
    tick();
    check("wr_grant3", 64'(grant_idx), 64'd3);
    check("wr_data3", out_data, 64'h30);
    tick();
    set_src(3, 1'b0, 4'h0, 64'd0, 1'b0);
    #1;
    check("wr_bubble", 64'(busy), 64'd0);
    tick();
    check("wr_grant0", 64'(grant_idx), 64'd0);
    check("wr_data0", out_data, 64'h10);
    tick();
    set_src(0, 1'b1, 4'h0, 64'h10, 1'b1);
    set_src(2, 1'b1, 4'h2, 64'h20, 1'b1);
    tick();
    check("wr_ptr1", 64'(grant_idx), 64'd2);
    tick();
    set_src(0, 1'b0, 4'h0, 64'd0, 1'b0);
    set_src(2, 1'b0, 4'h0, 64'd0, 1'b0);

    // Contention after reset: sources 0,1,3 with 2-beat bursts
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NS; i++) beat[i] = 0;
    set_src(0, 1'b1, 4'h0, 64'd0, 1'b0);
    set_src(1, 1'b1, 4'h1, 64'd0, 1'b0);
    set_src(3, 1'b1, 4'h3, 64'd0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      #1;
      code = out_valid ? {out_id, out_data[3:0]} : 8'hFF;
      check("ct_seq", 64'(code), 64'(exp_code[c]));
      hs = src_valid & src_ready;
      tick();
      for (int i = 0; i < NS; i++) begin
        if (hs[i]) begin
          beat[i]++;
          if (beat[i] == 2) set_src(i, 1'b0, 4'h0, 64'd0, 1'b0);
          else set_src(i, 1'b1, 4'(i), 64'(beat[i]), (beat[i] == 1));
        end
      end
    end
`ifdef R_ARB_BURST_CNT_EN
    check("cnt_three", 64'(burst_cnt), 64'd3);
`endif

    // Backpressure: src 1, 3 beats, out_ready 1,0,0,1,1
    bp_beat = 0;
    set_src(1, 1'b1, 4'h1, 64'hA0, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      out_ready = bp_rdy[c];
      #1;
      check("bp_data", out_data, bp_data[c]);
      check("bp_ready", 64'(src_ready), bp_rdy[c] ? 64'b0010 : 64'd0);
      hs[0] = out_valid & out_ready;
      tick();
      if (hs[0]) begin
        bp_beat++;
        if (bp_beat == 3) set_src(1, 1'b0, 4'h0, 64'd0, 1'b0);
        else set_src(1, 1'b1, 4'h1, 64'hA0 + 64'(bp_beat), (bp_beat == 2));
      end
    end
    out_ready = 1'b1;
    #1;
    check("bp_done_busy", 64'(busy), 64'd0);

    // Reset mid-burst: src 3 8-beat burst (ptr=2), reset on beat 2
    set_src(3, 1'b1, 4'h3, 64'd0, 1'b0);
    tick();
    check("mr_grant3", 64'(grant_idx), 64'd3);
    for (int b = 0; b < 2; b++) begin
      tick();
      set_src(3, 1'b1, 4'h3, 64'(b + 1), 1'b0);
    end
    #1;
    check("mr_beat2", out_data, 64'd2);
    rst = 1'b1;
    #1;
    check("mr_rst_valid", 64'(out_valid), 64'd0);
    check("mr_rst_ready", 64'(src_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_valid", 64'(out_valid), 64'd0);
    set_src(1, 1'b1, 4'h1, 64'h77, 1'b1);
    tick();
    check("mr_regrant", 64'(grant_idx), 64'd1);
    check("mr_regrant_id", 64'(out_id), 64'h1);
    tick();
    set_src(1, 1'b0, 4'h0, 64'd0, 1'b0);
    set_src(3, 1'b0, 4'h0, 64'd0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
